// File: rtl/dtc_frame_feeder.sv
// ---------------------------------------------------------------------------
// dtc_frame_feeder
//
// Feeder/collector wrapped around a purely combinational decision-tree
// classifier. Feature bits arrive one per accepted cycle, LSB first, and are
// assembled in a shift register that drives the classifier input directly.
// Once a full vector is in place the feeder waits a fixed number of settle
// cycles, captures the classifier's class code together with the vector that
// produced it, and presents both on a single-entry valid/ready result port.
//
// Parameters:
//   FEAT_W  feature vector width (matches classifier input)
//   CLS_W   class code width (matches classifier output)
//   SETTLE  cycles the vector is held before the class code is captured (1..15)
//   CNT_W   width of the accepted-result counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   s_bit      serial feature bit
//   s_valid    s_bit is valid this cycle
//   s_ready    feeder can accept a bit (only while accumulating)
//   s_abort    discard the partially assembled frame
//   feat_o     feature vector driven to the classifier input
//   cls_i      class code returned by the classifier
//   m_valid    a captured result is being held
//   m_ready    downstream accepts the held result
//   m_class    captured class code
//   m_feat     feature vector that produced m_class
//   frame_cnt  number of results accepted downstream (wraps)
// ---------------------------------------------------------------------------
module dtc_frame_feeder #(
  parameter int FEAT_W = 11,
  parameter int CLS_W  = 3,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_bit,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_abort,
  output logic [FEAT_W-1:0] feat_o,
  input  logic [CLS_W-1:0]  cls_i,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CLS_W-1:0]  m_class,
  output logic [FEAT_W-1:0] m_feat,
  output logic [CNT_W-1:0]  frame_cnt
);

  // Bit counter must reach FEAT_W-1; the settle counter holds up to 14.
  localparam int BIT_W = (FEAT_W > 1) ? $clog2(FEAT_W) : 1;
  localparam int SET_W = 4;

  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(FEAT_W - 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    WAIT  = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t           state;
  logic [BIT_W-1:0] bit_cnt;
  logic [SET_W-1:0] settle_cnt;

  // The serial side is only open while accumulating; decoding it straight
  // from the state register keeps any input out of the ready path, and
  // naturally back-pressures the sensor while a result is pending.
  assign s_ready = (state == ACCUM);

  // Single FSM carrying the shift register, the two counters and the result
  // buffer. feat_o is deliberately left untouched outside ACCUM so the
  // classifier sees a constant input from the last accepted bit until
  // capture, and keeps showing the last vector until the next frame starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      bit_cnt    <= '0;
      settle_cnt <= '0;
      feat_o     <= '0;
      m_valid    <= 1'b0;
      m_class    <= '0;
      m_feat     <= '0;
      frame_cnt  <= '0;
    end else begin
      case (state)
        ACCUM: begin
          // Abort wins over a simultaneous bit, which is dropped.
          if (s_abort) begin
            bit_cnt <= '0;
            feat_o  <= '0;
          end else if (s_valid) begin
            feat_o <= {s_bit, feat_o[FEAT_W-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt    <= '0;
              settle_cnt <= SETTLE_LOAD;
              state      <= WAIT;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        WAIT: begin
          // Capture on the edge where the countdown has already reached 0,
          // giving exactly SETTLE cycles between last bit and m_valid.
          if (settle_cnt == '0) begin
            m_class <= cls_i;
            m_feat  <= feat_o;
            m_valid <= 1'b1;
            state   <= OUT;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        OUT: begin
          if (m_ready) begin
            m_valid   <= 1'b0;
            frame_cnt <= frame_cnt + 1'b1;
            state     <= ACCUM;
          end
        end

        default: begin
          m_valid <= 1'b0;
          state   <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtc_frame_feeder.sv
// ---------------------------------------------------------------------------
// tb_dtc_frame_feeder
//
// Self-checking bench for dtc_frame_feeder. Two instances share clock and
// reset: dut_a (SETTLE=1, CNT_W=4) covers reset, single frame, back-pressure,
// abort and counter wrap; dut_b (SETTLE=4) covers the longer settle time with
// gaps in the serial stream. Both are tied to the model classifier
// cls = feat[2:0] ^ 3'b101. Expected results are queued when a frame is
// driven and popped when the feeder presents its result.
// ---------------------------------------------------------------------------
module tb_dtc_frame_feeder;

  typedef struct packed {
    logic [10:0] feat;
    logic [2:0]  cls;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Instance A signals
  logic        s_bit_a = 1'b0, s_valid_a = 1'b0, s_abort_a = 1'b0, m_ready_a = 1'b0;
  logic        s_ready_a, m_valid_a;
  logic [10:0] feat_a, m_feat_a;
  logic [2:0]  cls_a, m_class_a;
  logic [3:0]  frame_cnt_a;

  // Instance B signals
  logic        s_bit_b = 1'b0, s_valid_b = 1'b0, s_abort_b = 1'b0, m_ready_b = 1'b0;
  logic        s_ready_b, m_valid_b;
  logic [10:0] feat_b, m_feat_b;
  logic [2:0]  cls_b, m_class_b;
  logic [15:0] frame_cnt_b;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  // Model classifiers tied to the feeder outputs
  assign cls_a = feat_a[2:0] ^ 3'b101;
  assign cls_b = feat_b[2:0] ^ 3'b101;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dtc_frame_feeder #(.FEAT_W(11), .CLS_W(3), .SETTLE(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_bit(s_bit_a), .s_valid(s_valid_a), .s_ready(s_ready_a), .s_abort(s_abort_a),
    .feat_o(feat_a), .cls_i(cls_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_class(m_class_a), .m_feat(m_feat_a),
    .frame_cnt(frame_cnt_a)
  );

  dtc_frame_feeder #(.FEAT_W(11), .CLS_W(3), .SETTLE(4), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_bit(s_bit_b), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_abort(s_abort_b),
    .feat_o(feat_b), .cls_i(cls_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_class(m_class_b), .m_feat(m_feat_b),
    .frame_cnt(frame_cnt_b)
  );

  function automatic logic [2:0] model_cls(input logic [10:0] f);
    return f[2:0] ^ 3'b101;
  endfunction

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_expected(input logic [10:0] f);
    exp_t e;
    e.feat = f;
    e.cls  = model_cls(f);
    exp_q.push_back(e);
  endfunction

  // Returns all-x when nothing is queued so any compare against it fails
  function automatic exp_t pop_expected();
    exp_t e;
    e = 'x;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    return e;
  endfunction

  // Drive one frame on instance A, LSB first, with optional idle gaps
  task automatic send_frame_a(input logic [10:0] f, input int max_gap, output int last_edge);
    for (int i = 0; i < 11; i++) begin
      if (max_gap > 0) begin
        s_valid_a = 1'b0;
        repeat ($urandom_range(0, max_gap)) tick();
      end
      s_valid_a = 1'b1;
      s_bit_a   = f[i];
      tick();
    end
    s_valid_a = 1'b0;
    last_edge = cyc;
  endtask

  task automatic wait_valid_a(input int budget, output bit ok);
    ok = m_valid_a;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = m_valid_a;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (m_valid_a !== 1'b0 || s_ready_a !== 1'b1 || feat_a !== 11'h000 || frame_cnt_a !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_init_a: m_valid=%b s_ready=%b feat_o=%h frame_cnt=%0d, expected 0 1 000 0",
               m_valid_a, s_ready_a, feat_a, frame_cnt_a);
    end
    checks++;
    if (m_valid_b !== 1'b0 || s_ready_b !== 1'b1 || feat_b !== 11'h000 || frame_cnt_b !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_init_b: m_valid=%b s_ready=%b feat_o=%h frame_cnt=%0d, expected 0 1 000 0",
               m_valid_b, s_ready_b, feat_b, frame_cnt_b);
    end
    rst_n = 1'b1;
    tick();
    // Five ones shifted in from the top
    for (int i = 0; i < 5; i++) begin
      s_valid_a = 1'b1;
      s_bit_a   = 1'b1;
      tick();
    end
    s_valid_a = 1'b0;
    checks++;
    if (feat_a !== 11'h7C0) begin
      errors++;
      $display("[TB] FAIL shift_partial: feat_o=%h, expected 7c0", feat_a);
    end
    // Mid-cycle reset must act without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid_a !== 1'b0 || s_ready_a !== 1'b1 || feat_a !== 11'h000 || frame_cnt_a !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_async: m_valid=%b s_ready=%b feat_o=%h frame_cnt=%0d, expected 0 1 000 0",
               m_valid_a, s_ready_a, feat_a, frame_cnt_a);
    end
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    tick();
  endtask

  task automatic test_single_frame();
    int   k;
    bit   ok;
    exp_t e;
    m_ready_a = 1'b1;
    push_expected(11'h001);
    send_frame_a(11'h001, 0, k);
    checks++;
    if (feat_a !== 11'h001 || m_valid_a !== 1'b0 || s_ready_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_assembled: feat_o=%h m_valid=%b s_ready=%b, expected 001 0 0",
               feat_a, m_valid_a, s_ready_a);
    end
    wait_valid_a(5, ok);
    checks++;
    if (!ok || (cyc - k) !== 1) begin
      errors++;
      $display("[TB] FAIL single_latency: valid=%b after %0d cycles, expected 1 after 1", ok, cyc - k);
    end
    e = pop_expected();
    checks++;
    if (m_class_a !== e.cls || m_feat_a !== e.feat || e.cls !== 3'b100) begin
      errors++;
      $display("[TB] FAIL single_result: m_class=%b m_feat=%h, expected %b %h",
               m_class_a, m_feat_a, e.cls, e.feat);
    end
    tick();
    checks++;
    if (m_valid_a !== 1'b0 || s_ready_a !== 1'b1 || frame_cnt_a !== 4'd1) begin
      errors++;
      $display("[TB] FAIL single_handshake: m_valid=%b s_ready=%b frame_cnt=%0d, expected 0 1 1",
               m_valid_a, s_ready_a, frame_cnt_a);
    end
  endtask

  task automatic test_back_pressure();
    int          k;
    bit          ok;
    exp_t        e;
    logic [10:0] f;
    f = 11'h2A5;
    m_ready_a = 1'b0;
    push_expected(f);
    send_frame_a(f, 0, k);
    s_valid_a = 1'b1;
    s_bit_a   = 1'b1;
    wait_valid_a(5, ok);
    e = pop_expected();
    checks++;
    if (!ok || m_class_a !== e.cls || m_feat_a !== e.feat) begin
      errors++;
      $display("[TB] FAIL bp_result: valid=%b m_class=%b m_feat=%h, expected 1 %b %h",
               ok, m_class_a, m_feat_a, e.cls, e.feat);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (s_ready_a !== 1'b0 || m_valid_a !== 1'b1 || m_class_a !== e.cls ||
          m_feat_a !== e.feat || feat_a !== f) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: s_ready=%b m_valid=%b m_class=%b m_feat=%h feat_o=%h, expected 0 1 %b %h %h",
                 i, s_ready_a, m_valid_a, m_class_a, m_feat_a, feat_a, e.cls, e.feat, f);
      end
    end
    m_ready_a = 1'b1;
    tick();
    checks++;
    if (m_valid_a !== 1'b0 || s_ready_a !== 1'b1 || feat_a !== f || frame_cnt_a !== 4'd2) begin
      errors++;
      $display("[TB] FAIL bp_release: m_valid=%b s_ready=%b feat_o=%h frame_cnt=%0d, expected 0 1 %h 2",
               m_valid_a, s_ready_a, feat_a, frame_cnt_a, f);
    end
    tick();
    checks++;
    if (feat_a !== {1'b1, f[10:1]}) begin
      errors++;
      $display("[TB] FAIL bp_first_bit: feat_o=%h, expected %h", feat_a, {1'b1, f[10:1]});
    end
    s_valid_a = 1'b0;
    s_abort_a = 1'b1;
    tick();
    s_abort_a = 1'b0;
    checks++;
    if (feat_a !== 11'h000) begin
      errors++;
      $display("[TB] FAIL bp_cleanup_abort: feat_o=%h, expected 000", feat_a);
    end
  endtask

  task automatic test_abort();
    int          k;
    bit          ok;
    bit          extra;
    exp_t        e;
    logic [4:0]  pre;
    pre = 5'b01101;
    m_ready_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_valid_a = 1'b1;
      s_bit_a   = pre[i];
      tick();
    end
    // Abort together with a valid bit: the bit must be dropped
    s_abort_a = 1'b1;
    s_valid_a = 1'b1;
    s_bit_a   = 1'b1;
    tick();
    s_abort_a = 1'b0;
    s_valid_a = 1'b0;
    checks++;
    if (feat_a !== 11'h000 || s_ready_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_clear: feat_o=%h s_ready=%b, expected 000 1", feat_a, s_ready_a);
    end
    push_expected(11'h7FF);
    send_frame_a(11'h7FF, 0, k);
    wait_valid_a(5, ok);
    e = pop_expected();
    checks++;
    if (!ok || m_class_a !== e.cls || m_feat_a !== e.feat || e.cls !== 3'b010) begin
      errors++;
      $display("[TB] FAIL abort_result: valid=%b m_class=%b m_feat=%h, expected 1 %b %h",
               ok, m_class_a, m_feat_a, e.cls, e.feat);
    end
    tick();
    extra = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (m_valid_a) extra = 1'b1;
      tick();
    end
    checks++;
    if (extra !== 1'b0 || frame_cnt_a !== 4'd3) begin
      errors++;
      $display("[TB] FAIL abort_single: extra_result=%b frame_cnt=%0d, expected 0 3", extra, frame_cnt_a);
    end
  endtask

  task automatic test_settle4();
    int          k;
    bit          seen;
    exp_t        e;
    logic [10:0] f;
    f = 11'($urandom_range(0, 2047));
    push_expected(f);
    for (int i = 0; i < 11; i++) begin
      s_valid_b = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      s_valid_b = 1'b1;
      s_bit_b   = f[i];
      tick();
    end
    s_valid_b = 1'b0;
    k = cyc;
    checks++;
    if (feat_b !== f || m_valid_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL settle4_assembled: feat_o=%h m_valid=%b, expected %h 0", feat_b, m_valid_b, f);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (m_valid_b) seen = 1'b1;
      else begin
        checks++;
        if (feat_b !== f || s_ready_b !== 1'b0) begin
          errors++;
          $display("[TB] FAIL settle4_hold: feat_o=%h s_ready=%b, expected %h 0", feat_b, s_ready_b, f);
        end
      end
    end
    checks++;
    if (!seen || (cyc - k) !== 4) begin
      errors++;
      $display("[TB] FAIL settle4_latency: valid=%b after %0d cycles, expected 1 after 4", seen, cyc - k);
    end
    e = pop_expected();
    checks++;
    if (m_class_b !== e.cls || m_feat_b !== e.feat) begin
      errors++;
      $display("[TB] FAIL settle4_result: m_class=%b m_feat=%h, expected %b %h",
               m_class_b, m_feat_b, e.cls, e.feat);
    end
    m_ready_b = 1'b1;
    tick();
    m_ready_b = 1'b0;
    checks++;
    if (m_valid_b !== 1'b0 || frame_cnt_b !== 16'd1) begin
      errors++;
      $display("[TB] FAIL settle4_handshake: m_valid=%b frame_cnt=%0d, expected 0 1", m_valid_b, frame_cnt_b);
    end
  endtask

  task automatic test_counter_wrap();
    int          k;
    int          prev_k;
    bit          ok;
    exp_t        e;
    logic [10:0] f;
    logic [3:0]  want;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    m_ready_a = 1'b1;
    prev_k = 0;
    for (int n = 1; n <= 17; n++) begin
      f = 11'($urandom_range(0, 2047));
      push_expected(f);
      send_frame_a(f, 0, k);
      if (n > 1) begin
        checks++;
        if ((k - prev_k) !== 13) begin
          errors++;
          $display("[TB] FAIL wrap_period[%0d]: %0d cycles, expected 13", n, k - prev_k);
        end
      end
      prev_k = k;
      wait_valid_a(4, ok);
      e = pop_expected();
      checks++;
      if (!ok || m_class_a !== e.cls || m_feat_a !== e.feat) begin
        errors++;
        $display("[TB] FAIL wrap_result[%0d]: valid=%b m_class=%b m_feat=%h, expected 1 %b %h",
                 n, ok, m_class_a, m_feat_a, e.cls, e.feat);
      end
      tick();
      want = 4'(n);
      checks++;
      if (frame_cnt_a !== want || s_ready_a !== 1'b1) begin
        errors++;
        $display("[TB] FAIL wrap_count[%0d]: frame_cnt=%0d s_ready=%b, expected %0d 1",
                 n, frame_cnt_a, s_ready_a, want);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting dtc_frame_feeder bench");
    test_reset();
    test_single_frame();
    test_back_pressure();
    test_abort();
    test_settle4();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
